mpb_reg_responder: RTL and testbench

//  Matrix Peripheral Bus (MPB) responder: the target end of the vld/rdy bus driven by an MPB initiator.

---
 rtl/mpb_reg_responder.sv | 173 +++++++++++++++++
 tb/tb_mpb_reg_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpb_reg_responder.sv
// ---------------------------------------------------------------------------
// mpb_reg_responder
//   Target end of the Matrix Peripheral Bus (vld/rdy). It backs DEPTH 32-bit
//   registers that start at byte address BASE_AADDR. Every transfer, whether it
//   hits or misses, is acknowledged after WAIT_CYCLES wait states.
//
//   The bus only allows one transfer at a time. An ACK cycle is always
//   followed by at least one IDLE cycle.
//
//   A miss is an address that is out of range or not 4-byte aligned. A write
//   that misses is dropped. A read that misses returns 32'hDEAD_BEEF.
//
//   If vld is withdrawn during the wait states, the transfer is aborted with
//   no side effects.
//
// Ports
//   clk        in   1           clock
//   reset      in   1           synchronous active-high reset
//   vld        in   1           request valid
//   wr         in   1           1 = write, 0 = read (qualified by vld)
//   addr       in   ADDR_WIDTH  byte address (qualified by vld)
//   wdata      in   DATA_WIDTH  write data (qualified by vld & wr)
//   rdy        out  1           acknowledge; the transfer completes on vld & rdy
//   rdata      out  DATA_WIDTH  read data; non-zero only while rdy & ~wr
//   wr_count   out  16          saturating count of acknowledged writes
//   rd_count   out  16          saturating count of acknowledged reads
//   err_count  out  16          saturating count of acknowledged misses
//
// Configuration macro
//   MPB_RESP_STATS_EN  When defined, adds the three counter ports and their
//                      logic. When undefined, the ports do not exist.
// ---------------------------------------------------------------------------
module mpb_reg_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vld,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdy,
    output logic [DATA_WIDTH-1:0] rdata
`ifdef MPB_RESP_STATS_EN
    ,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic [15:0]           err_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              wait_cnt;
    logic [ADDR_WIDTH-1:0]   off;
    logic                    hit;
    logic [IDX_W-1:0]        idx;
    logic                    ack_xfer;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    // Address decode. The subtraction wraps, so any address below BASE_ADDR
    // becomes a large offset and fails the range test.
    always_comb begin
        off = addr - BASE_ADDR;
        hit = (off < ADDR_WIDTH'(DEPTH * 4)) && (addr[1:0] == 2'b00);
        idx = off[IDX_W+1:2];
    end

    // NOTE: every output of a combinational block gets a default value
    // first, so no path through the case can leave it unassigned and infer
    // a latch.
    always_comb begin
        next_state = state;
        rdy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (vld) begin
                    next_state = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!vld) begin
                    next_state = S_IDLE;           // initiator broke protocol: abort
                end else if (wait_cnt == 4'd0) begin
                    next_state = S_ACK;
                end
            end
            S_ACK: begin
                rdy        = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A transfer takes effect only on the edge that ends the ACK cycle.
    assign ack_xfer = (state == S_ACK) && vld;

    // NOTE: state is updated with non-blocking assignments, so every
    // always_ff block samples the values from before the edge, no matter
    // which order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && vld) begin
                wait_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (state == S_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Read data is captured as the FSM enters ACK. It is zero in every other
    // cycle, so the initiator never sees stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (next_state == S_ACK && !wr) begin
            rdata <= hit ? regs[idx] : DATA_WIDTH'(32'hDEAD_BEEF);
        end else begin
            rdata <= '0;
        end
    end

    // NOTE: this register bank is reset on purpose. Reads must return zero
    // straight after reset, so it is built from resettable flops rather than
    // an uninitialised RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (ack_xfer && wr && hit) begin
            regs[idx] <= wdata;
        end
    end

`ifdef MPB_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count  <= '0;
            rd_count  <= '0;
            err_count <= '0;
        end else if (ack_xfer) begin
            if (wr && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (!wr && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (!hit && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mpb_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_mpb_reg_responder
//   Drives two responders that share a clock and a reset. Both use
//   BASE_ADDR = 0 and DEPTH = 16:
//     index 1 : WAIT_CYCLES = 2
//     index 0 : WAIT_CYCLES = 0
//
//   For each request, the stimulus tasks push the expected read data and
//   the expected acknowledge cycle into a per-instance queue. A monitor runs
//   on every falling edge. Whenever rdy is high it pops the queue and
//   compares. Whenever rdy is low it checks that rdata is zero.
// ---------------------------------------------------------------------------
module tb_mpb_reg_responder;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        vld_b   [2];
    logic        wr_b    [2];
    logic        rdy_b   [2];
    logic [31:0] addr_b  [2];
    logic [31:0] wdata_b [2];
    logic [31:0] rdata_b [2];
`ifdef MPB_RESP_STATS_EN
    logic [15:0] wrc_b   [2];
    logic [15:0] rdc_b   [2];
    logic [15:0] errc_b  [2];
`endif

    exp_t        q0[$];
    exp_t        q2[$];
    logic [31:0] model [2][16];
    int          cyc;
    bit          mon_en;
    int          n_cmp;
    int          n_err;

    mpb_reg_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0),
        .WAIT_CYCLES(2)
    ) u_w2 (
        .clk      (clk),
        .reset    (reset),
        .vld      (vld_b[1]),
        .wr       (wr_b[1]),
        .addr     (addr_b[1]),
        .wdata    (wdata_b[1]),
        .rdy      (rdy_b[1]),
        .rdata    (rdata_b[1])
`ifdef MPB_RESP_STATS_EN
        ,
        .wr_count (wrc_b[1]),
        .rd_count (rdc_b[1]),
        .err_count(errc_b[1])
`endif
    );

    mpb_reg_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0),
        .WAIT_CYCLES(0)
    ) u_w0 (
        .clk      (clk),
        .reset    (reset),
        .vld      (vld_b[0]),
        .wr       (wr_b[0]),
        .addr     (addr_b[0]),
        .wdata    (wdata_b[0]),
        .rdy      (rdy_b[0]),
        .rdata    (rdata_b[0])
`ifdef MPB_RESP_STATS_EN
        ,
        .wr_count (wrc_b[0]),
        .rd_count (rdc_b[0]),
        .err_count(errc_b[0])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges; the value read after edge k is k.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_read(input int sel, input logic [31:0] a);
        if (a < 32'h40 && a[1:0] == 2'b00) begin
            return model[sel][a[5:2]];
        end
        return 32'hDEAD_BEEF;
    endfunction

    task automatic push(input int sel, input logic [31:0] d, input int c);
        exp_t e;
        e.rdata = d;
        e.cyc   = c;
        if (sel == 1) q2.push_back(e);
        else          q0.push_back(e);
    endtask

    task automatic mon(input int sel);
        exp_t  e;
        int    qs;
        string tag;
        tag = (sel == 1) ? "w2" : "w0";
        qs  = (sel == 1) ? q2.size() : q0.size();
        if (rdy_b[sel]) begin
            if (qs == 0) begin
                check({tag, "_unexpected_rdy"}, 32'(rdy_b[sel]), 32'h0);
            end else begin
                if (sel == 1) e = q2.pop_front();
                else          e = q0.pop_front();
                check({tag, "_rdata"}, rdata_b[sel], e.rdata);
                check({tag, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end else begin
            check({tag, "_idle_rdata"}, rdata_b[sel], 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0);
            mon(1);
        end
    end

    // One complete transfer. vld is held until the edge that ends the ACK
    // cycle. The expected acknowledge arrives WAIT_CYCLES+1 edges after the
    // request is driven.
    task automatic xfer(input int sel, input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] e;
        bit          seen;
        int          lat;
        lat = (sel == 1) ? 3 : 1;
        e   = w ? 32'h0 : exp_read(sel, a);
        @(posedge clk);
        #1;
        vld_b[sel]   = 1'b1;
        wr_b[sel]    = w;
        addr_b[sel]  = a;
        wdata_b[sel] = d;
        push(sel, e, cyc + lat);
        if (w && a < 32'h40 && a[1:0] == 2'b00) model[sel][a[5:2]] = d;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = rdy_b[sel];
        end
        check("ack_seen", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        vld_b[sel] = 1'b0;
        wr_b[sel]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MPB_RESP_STATS_EN
        logic [15:0] snap_wr;
        logic [15:0] snap_rd;
        logic [15:0] snap_err;
`endif
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        reset  = 1'b1;
        for (int s = 0; s < 2; s++) begin
            vld_b[s]   = 1'b0;
            wr_b[s]    = 1'b0;
            addr_b[s]  = 32'h0;
            wdata_b[s] = 32'h0;
            for (int i = 0; i < 16; i++) model[s][i] = 32'h0;
        end

        // Hold reset for 3 cycles, release it, then read every index on both instances.
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_rdy_w2",   32'(rdy_b[1]), 32'h0);
        check("reset_rdata_w2", rdata_b[1],    32'h0);
        check("reset_rdy_w0",   32'(rdy_b[0]), 32'h0);
        check("reset_rdata_w0", rdata_b[0],    32'h0);
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) xfer(1, 1'b0, 32'(i * 4), 32'h0);
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0);

        // WAIT_CYCLES=2: write a register, then read it back.
        xfer(1, 1'b1, 32'h8, 32'hA5A5_0001);
        xfer(1, 1'b0, 32'h8, 32'h0);

        // Out-of-range and misaligned reads return DEAD_BEEF; a write that misses changes nothing.
        xfer(1, 1'b0, 32'h40, 32'h0);
        xfer(1, 1'b0, 32'h6,  32'h0);
`ifdef MPB_RESP_STATS_EN
        check("err_count_after_misses", 32'(errc_b[1]), 32'h2);
`endif
        xfer(1, 1'b1, 32'h40, 32'h5555_5555);
        for (int i = 0; i < 16; i++) xfer(1, 1'b0, 32'(i * 4), 32'h0);

        // vld dropped during WAIT: no rdy, register and counters unchanged.
        xfer(1, 1'b1, 32'hC, 32'h0000_00CC);
`ifdef MPB_RESP_STATS_EN
        snap_wr  = wrc_b[1];
        snap_rd  = rdc_b[1];
        snap_err = errc_b[1];
`endif
        @(posedge clk);
        #1;
        vld_b[1]   = 1'b1;
        wr_b[1]    = 1'b1;
        addr_b[1]  = 32'hC;
        wdata_b[1] = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        vld_b[1] = 1'b0;
        wr_b[1]  = 1'b0;
        repeat (4) @(posedge clk);
`ifdef MPB_RESP_STATS_EN
        check("abort_wr_count",  32'(wrc_b[1]),  32'(snap_wr));
        check("abort_rd_count",  32'(rdc_b[1]),  32'(snap_rd));
        check("abort_err_count", 32'(errc_b[1]), 32'(snap_err));
`endif
        xfer(1, 1'b0, 32'hC, 32'h0);

        // WAIT_CYCLES=0: 8 back-to-back writes with vld held high, so rdy alternates 1,0.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            vld_b[0]   = 1'b1;
            wr_b[0]    = 1'b1;
            addr_b[0]  = 32'(i * 4);
            wdata_b[0] = 32'hB0B0_0000 + 32'(i);
            push(0, 32'h0, cyc + 1);
            model[0][i] = 32'hB0B0_0000 + 32'(i);
            @(posedge clk);
            @(posedge clk);
            #1;
        end
        vld_b[0] = 1'b0;
        wr_b[0]  = 1'b0;
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0);

        // Reset pulsed during WAIT of a write: no rdy, and all registers are cleared.
        @(posedge clk);
        #1;
        vld_b[1]   = 1'b1;
        wr_b[1]    = 1'b1;
        addr_b[1]  = 32'h4;
        wdata_b[1] = 32'h0000_1234;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        vld_b[1] = 1'b0;
        wr_b[1]  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) model[s][i] = 32'h0;
        end
        xfer(1, 1'b0, 32'h4, 32'h0);
        xfer(1, 1'b0, 32'h8, 32'h0);
        xfer(0, 1'b0, 32'h0, 32'h0);

        repeat (4) @(posedge clk);
        check("w2_queue_drained", 32'(q2.size()), 32'h0);
        check("w0_queue_drained", 32'(q0.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
